// File: rtl/sprite_address_pipe.sv
// sprite_address_pipe: double-buffered multi-slot sprite hit test and ROM address generator, 3-cycle latency
module sprite_address_pipe #(
   parameter int SIZE_X       = 10,
   parameter int SIZE_Y       = 10,
   parameter int SIZE_ADDRESS = 14,
   parameter int SPRITE_W     = 20,
   parameter int SPRITE_H     = 20,
   parameter int NUM_SLOTS    = 4,
   parameter int SLOT_W       = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [SLOT_W-1:0]       wr_slot,
   input  logic [31:0]             wr_data,
   input  logic                    frame_start,
   input  logic                    pixel_valid,
   input  logic [SIZE_X-1:0]       pixel_x,
   input  logic [SIZE_Y-1:0]       pixel_y,
   output logic                    out_valid,
   output logic [SIZE_ADDRESS-1:0] memory_address,
   output logic                    is_sprite,
   output logic [SLOT_W-1:0]       hit_slot,
   output logic                    collision
);
   localparam int AW = SIZE_ADDRESS;

   typedef struct packed {
      logic       en;
      logic [9:0] x;
      logic [9:0] y;
      logic [8:0] off;
   } desc_t;

   desc_t shadow [NUM_SLOTS];
   desc_t active [NUM_SLOTS];
   desc_t shadow_nx [NUM_SLOTS];

   logic unused_desc_bits;
   assign unused_desc_bits = ^wr_data[30:29];

   // shadow table with this cycle's write applied, so a commit in the same cycle sees it
   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++)
         shadow_nx[s] = (wr_en && wr_slot == SLOT_W'(s)) ? desc_t'({wr_data[31], wr_data[28:0]}) : shadow[s];
   end

   // descriptor tables: shadow takes writes, active is loaded on frame start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            shadow[s] <= '0;
            active[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            shadow[s] <= shadow_nx[s];
            if (frame_start) active[s] <= shadow_nx[s];
         end
      end
   end

   logic [AW-1:0]        px_e, py_e;
   logic [NUM_SLOTS-1:0] hit_c;
   logic [AW-1:0]        col_c [NUM_SLOTS];
   logic [AW-1:0]        row_c [NUM_SLOTS];

   assign px_e = AW'(pixel_x);
   assign py_e = AW'(pixel_y);

   // per-slot bounds test; limits are formed at address width so edge sprites do not wrap
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      assign hit_c[g] = active[g].en
         && px_e >= AW'(active[g].x) && px_e < AW'(active[g].x) + AW'(SPRITE_W)
         && py_e >= AW'(active[g].y) && py_e < AW'(active[g].y) + AW'(SPRITE_H);
      assign col_c[g] = px_e - AW'(active[g].x);
      assign row_c[g] = py_e - AW'(active[g].y);
   end

   logic                 s1_valid;
   logic [NUM_SLOTS-1:0] s1_hit;
   logic [AW-1:0]        s1_col [NUM_SLOTS];
   logic [AW-1:0]        s1_row [NUM_SLOTS];
   logic [8:0]           s1_off [NUM_SLOTS];

   // stage 1: capture hit vector, offsets and slot-relative coordinates
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_hit   <= '0;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            s1_col[s] <= '0;
            s1_row[s] <= '0;
            s1_off[s] <= '0;
         end
      end else begin
         s1_valid <= pixel_valid;
         s1_hit   <= hit_c;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            s1_col[s] <= col_c[s];
            s1_row[s] <= row_c[s];
            s1_off[s] <= active[s].off;
         end
      end
   end

   logic              sel_any, sel_coll;
   logic [SLOT_W-1:0] sel_slot;
   logic [AW-1:0]     sel_col, sel_row;
   logic [8:0]        sel_off;

   // lowest-index hit wins; scanning downward lets the lowest index overwrite last
   always_comb begin
      sel_any  = 1'b0;
      sel_slot = '0;
      sel_col  = '0;
      sel_row  = '0;
      sel_off  = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (s1_hit[s]) begin
            sel_any  = 1'b1;
            sel_slot = SLOT_W'(s);
            sel_col  = s1_col[s];
            sel_row  = s1_row[s];
            sel_off  = s1_off[s];
         end
      end
   end

   assign sel_coll = $countones(s1_hit) >= 2;

   logic              s2_valid, s2_any, s2_coll;
   logic [SLOT_W-1:0] s2_slot;
   logic [AW-1:0]     s2_col, s2_row;
   logic [8:0]        s2_off;

   // stage 2: register the winner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_any   <= 1'b0;
         s2_coll  <= 1'b0;
         s2_slot  <= '0;
         s2_col   <= '0;
         s2_row   <= '0;
         s2_off   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_any   <= sel_any;
         s2_coll  <= sel_coll;
         s2_slot  <= sel_slot;
         s2_col   <= sel_col;
         s2_row   <= sel_row;
         s2_off   <= sel_off;
      end
   end

   logic [AW-1:0] addr_c;
   logic          hit_out;

   assign addr_c  = AW'(s2_off) * AW'(SPRITE_W * SPRITE_H) + s2_row * AW'(SPRITE_W) + s2_col;
   assign hit_out = s2_valid && s2_any;

   // stage 3: outputs, with defaults on bubbles and misses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid      <= 1'b0;
         memory_address <= '1;
         is_sprite      <= 1'b0;
         hit_slot       <= '0;
         collision      <= 1'b0;
      end else begin
         out_valid      <= s2_valid;
         memory_address <= hit_out ? addr_c : '1;
         is_sprite      <= hit_out;
         hit_slot       <= hit_out ? s2_slot : '0;
         collision      <= s2_valid && s2_coll;
      end
   end
endmodule

// File: tb/tb_sprite_address_pipe.sv
// tb_sprite_address_pipe: directed and scoreboard checks of the sprite address pipeline
module tb_sprite_address_pipe;
   logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, frame_start = 1'b0, pixel_valid = 1'b0;
   logic [1:0]  wr_slot = '0;
   logic [31:0] wr_data = '0;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic        out_valid, is_sprite, collision;
   logic [1:0]  hit_slot;
   logic [13:0] memory_address;
   int          checks = 0, errors = 0;
   logic [31:0] sh [4];
   logic [31:0] act [4];
   logic [31:0] exp_q [1000];

   always #5 clk = ~clk;

   sprite_address_pipe dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
      .frame_start(frame_start), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .out_valid(out_valid), .memory_address(memory_address), .is_sprite(is_sprite),
      .hit_slot(hit_slot), .collision(collision)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] desc(input int en, input int x, input int y, input int off);
      return {en[0], 2'b00, x[9:0], y[9:0], off[8:0]};
   endfunction

   function automatic logic [31:0] pack(input int v, input int s, input int slot, input int c, input int addr);
      return {13'd0, v[0], s[0], slot[1:0], c[0], addr[13:0]};
   endfunction

   function automatic logic [31:0] obs();
      return {13'd0, out_valid, is_sprite, hit_slot, collision, memory_address};
   endfunction

   function automatic logic [31:0] model(input int px, input int py);
      int n = 0, slot = 0, addr = 16383;
      for (int s = 0; s < 4; s++) begin
         int x = int'(act[s][28:19]);
         int y = int'(act[s][18:9]);
         int off = int'(act[s][8:0]);
         if (act[s][31] && px >= x && px < x + 20 && py >= y && py < y + 20) begin
            n++;
            if (n == 1) begin
               slot = s;
               addr = (off * 400 + (py - y) * 20 + (px - x)) % 16384;
            end
         end
      end
      return pack(1, n > 0, slot, n >= 2, addr);
   endfunction

   task automatic copy_table();
      for (int s = 0; s < 4; s++) act[s] = sh[s];
   endtask

   task automatic wr(input int slot, input logic [31:0] d, input logic fs);
      @(negedge clk);
      wr_en = 1'b1; wr_slot = slot[1:0]; wr_data = d; frame_start = fs;
      sh[slot] = d;
      if (fs) copy_table();
      @(negedge clk);
      wr_en = 1'b0; frame_start = 1'b0;
   endtask

   task automatic commit();
      @(negedge clk);
      frame_start = 1'b1;
      copy_table();
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic send(input int x, input int y);
      @(negedge clk);
      pixel_valid = 1'b1; pixel_x = x[9:0]; pixel_y = y[9:0];
      @(negedge clk);
      pixel_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int s = 0; s < 4; s++) begin sh[s] = '0; act[s] = '0; end
      @(negedge clk);
      check("reset_state", obs(), pack(0, 0, 0, 0, 16383));
      reset = 1'b0;
      wr(0, desc(1, 100, 50, 2), 1'b0);
      commit();
      send(105, 53);  check("single_hit", obs(), pack(1, 1, 0, 0, 865));
      @(negedge clk); check("bubble", obs(), pack(0, 0, 0, 0, 16383));
      send(119, 69);  check("corner_in", obs(), pack(1, 1, 0, 0, 1199));
      send(120, 50);  check("x_excl", obs(), pack(1, 0, 0, 0, 16383));
      send(100, 70);  check("y_excl", obs(), pack(1, 0, 0, 0, 16383));
      send(100, 50);  check("origin_in", obs(), pack(1, 1, 0, 0, 800));
      send(99, 50);   check("x_below", obs(), pack(1, 0, 0, 0, 16383));
      wr(0, 32'h0000_0001, 1'b0);
      wr(1, desc(1, 90, 50, 3), 1'b0);
      wr(3, desc(1, 100, 50, 0), 1'b0);
      commit();
      send(105, 55);  check("priority", obs(), pack(1, 1, 1, 1, 1315));
      send(105, 60);  check("priority2", obs(), pack(1, 1, 1, 1, 1415));
      send(115, 55);  check("slot3_only", obs(), pack(1, 1, 3, 0, 115));
      send(0, 0);     check("legacy_desc", obs(), pack(1, 0, 0, 0, 16383));
      wr(0, desc(1, 0, 0, 1), 1'b0);
      send(0, 0);     check("shadow_only", obs(), pack(1, 0, 0, 0, 16383));
      commit();
      send(0, 0);     check("committed", obs(), pack(1, 1, 0, 0, 400));
      send(19, 19);   check("committed_far", obs(), pack(1, 1, 0, 0, 799));
      @(negedge clk);
      wr_en = 1'b1; wr_slot = 2'd2; wr_data = desc(1, 1015, 1010, 4) | 32'h6000_0000; frame_start = 1'b1;
      pixel_valid = 1'b1; pixel_x = 10'd1023; pixel_y = 10'd1023;
      sh[2] = wr_data;
      copy_table();
      @(negedge clk);
      wr_en = 1'b0; frame_start = 1'b0;
      @(negedge clk);
      pixel_valid = 1'b0;
      @(negedge clk); check("commit_edge_old", obs(), pack(1, 0, 0, 0, 16383));
      @(negedge clk); check("write_through", obs(), pack(1, 1, 2, 0, 1868));
      for (int k = 0; k < 1003; k++) begin
         int px, py;
         @(negedge clk);
         if (k >= 3) check("stream", obs(), exp_q[k-3]);
         if (k < 1000) begin
            case (k % 4)
               0: begin px = 85 + (k * 3) % 45;  py = 45 + (k * 7) % 30;    end
               1: begin px = k % 25;             py = (k / 4) % 25;         end
               2: begin px = 1005 + k % 19;      py = 1000 + (k * 5) % 24;  end
               default: begin px = (k * 37) % 1024; py = (k * 11) % 1024; end
            endcase
            pixel_valid = 1'b1; pixel_x = px[9:0]; pixel_y = py[9:0];
            exp_q[k] = model(px, py);
         end else pixel_valid = 1'b0;
      end
      wr(2, desc(1, 1015, 1010, 511), 1'b1);
      send(1015, 1010); check("offset_wrap", obs(), pack(1, 1, 2, 0, 7792));
      @(negedge clk);
      pixel_valid = 1'b1; pixel_x = 10'd105; pixel_y = 10'd55;
      repeat (3) @(negedge clk);
      check("pre_reset", obs(), pack(1, 1, 1, 1, 1315));
      reset = 1'b1;
      #1 check("reset_async", obs(), pack(0, 0, 0, 0, 16383));
      @(negedge clk);
      reset = 1'b0;
      #1 check("release_c0", obs(), pack(0, 0, 0, 0, 16383));
      @(negedge clk); check("release_c1", obs(), pack(0, 0, 0, 0, 16383));
      @(negedge clk); check("release_c2", obs(), pack(0, 0, 0, 0, 16383));
      @(negedge clk); check("release_c3", obs(), pack(1, 0, 0, 0, 16383));
      pixel_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
